// File: rtl/fx_delay_line.sv
// Valid-qualified, stallable, flushable delay line that balances latency between
// parallel fixed-point datapath branches; also reports how many valid samples are in flight.
module fx_delay_line #(
    parameter int DW    = 14,
    parameter int DEPTH = 1,
    localparam int CW   = ($clog2(DEPTH + 1) > 1) ? $clog2(DEPTH + 1) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    input  logic          i_flush,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic [CW-1:0] o_fill
);

    generate
        if (DEPTH == 0) begin : g_bypass
            // Zero depth is a pure wire; control inputs have no effect.
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, clk, rst_n, i_en, i_flush};

            assign o_data  = i_data;
            assign o_valid = i_valid;
            assign o_fill  = '0;
        end else begin : g_stages
            localparam logic [CW:0] MAX_FILL = (CW + 1)'(DEPTH);

            logic [DEPTH-1:0][DW-1:0] data_q;
            logic [DEPTH-1:0]         valid_q;
            logic [CW-1:0]            fill_q;

            // Flush clears only the valid bits; stale data is masked by o_valid.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q  <= '0;
                    valid_q <= '0;
                    fill_q  <= '0;
                end else if (i_flush) begin
                    valid_q <= '0;
                    fill_q  <= '0;
                end else if (i_en) begin
                    data_q[0]  <= i_data;
                    valid_q[0] <= i_valid;
                    for (int k = 1; k < DEPTH; k++) begin
                        data_q[k]  <= data_q[k-1];
                        valid_q[k] <= valid_q[k-1];
                    end
                    fill_q <= fill_q + CW'(i_valid) - CW'(valid_q[DEPTH-1]);
                end
            end

            assign o_data  = data_q[DEPTH-1];
            assign o_valid = valid_q[DEPTH-1];
            assign o_fill  = fill_q;

            // The occupancy count can never exceed the number of stages.
            assert property (@(posedge clk) disable iff (!rst_n) {1'b0, fill_q} <= MAX_FILL)
                else $error("fill count out of range");
        end
    endgenerate

endmodule
